// File: rtl/sram_bus_arbiter.sv
// rtl/sram_bus_arbiter.sv - two-master sram-like bus arbiter with one outstanding transaction
// Data side has priority; inst is forced through after STARVE_MAX consecutive data grants.
module sram_bus_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        i_clk,
  input  logic        i_resetn,
  input  logic        i_inst_req,
  input  logic        i_inst_wr,
  input  logic [1:0]  i_inst_size,
  input  logic [31:0] i_inst_addr,
  input  logic [31:0] i_inst_wdata,
  output logic        o_inst_addr_ok,
  output logic        o_inst_data_ok,
  output logic [31:0] o_inst_rdata,
  input  logic        i_data_req,
  input  logic        i_data_wr,
  input  logic [1:0]  i_data_size,
  input  logic [31:0] i_data_addr,
  input  logic [31:0] i_data_wdata,
  output logic        o_data_addr_ok,
  output logic        o_data_data_ok,
  output logic [31:0] o_data_rdata,
  output logic        o_mem_req,
  output logic        o_mem_wr,
  output logic [1:0]  o_mem_size,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_addr_ok,
  input  logic        i_mem_data_ok,
  input  logic [31:0] i_mem_rdata,
  output logic        o_stray_ok
);

  localparam logic [2:0] C_STARVE_MAX = 3'(STARVE_MAX);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_owner;
  logic        w_owner_nxt;
  logic [2:0]  r_starve_cnt;
  logic [2:0]  w_starve_nxt;
  logic        r_rst_hold;
  logic        w_idle;
  logic        w_grant_inst;
  logic        w_addr_hs;

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_state      <= S_IDLE;
      r_owner      <= 1'b0;
      r_starve_cnt <= 3'd0;
      r_rst_hold   <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_owner      <= w_owner_nxt;
      r_starve_cnt <= w_starve_nxt;
      r_rst_hold   <= 1'b0;
    end
  end

  always_comb begin
    // While reset is held the bus already looks idle, so nothing is routed back.
    w_idle       = (r_state == S_IDLE) || !i_resetn;
    w_grant_inst = i_inst_req && (!i_data_req || (r_starve_cnt == C_STARVE_MAX));

    o_mem_req    = w_idle && (i_inst_req || i_data_req);
    o_mem_wr     = w_grant_inst ? i_inst_wr    : i_data_wr;
    o_mem_size   = w_grant_inst ? i_inst_size  : i_data_size;
    o_mem_addr   = w_grant_inst ? i_inst_addr  : i_data_addr;
    o_mem_wdata  = w_grant_inst ? i_inst_wdata : i_data_wdata;

    o_inst_addr_ok = w_idle &&  w_grant_inst && i_mem_addr_ok;
    o_data_addr_ok = w_idle && !w_grant_inst && i_mem_addr_ok;

    o_inst_data_ok = !w_idle && !r_owner && i_mem_data_ok;
    o_data_data_ok = !w_idle &&  r_owner && i_mem_data_ok;
    o_stray_ok     = w_idle && i_resetn && !r_rst_hold && i_mem_data_ok;

    o_inst_rdata = i_mem_rdata;
    o_data_rdata = i_mem_rdata;

    w_addr_hs    = w_idle && o_mem_req && i_mem_addr_ok;
    w_state_nxt  = r_state;
    w_owner_nxt  = r_owner;
    w_starve_nxt = r_starve_cnt;

    case (r_state)
      S_IDLE: begin
        if (w_addr_hs) begin
          w_state_nxt = S_WAIT;
          w_owner_nxt = !w_grant_inst;
          if (w_grant_inst || !i_inst_req) begin
            w_starve_nxt = 3'd0;
          end else if (r_starve_cnt < C_STARVE_MAX) begin
            w_starve_nxt = r_starve_cnt + 3'd1;
          end
        end
      end
      S_WAIT: begin
        if (i_mem_data_ok) begin
          w_state_nxt = S_IDLE;
        end
      end
    endcase
  end

endmodule

// File: doc/sram_bus_arbiter.md
SRAM_BUS_ARBITER -- requirements
Module: sram_bus_arbiter

Interface
REQ-001 Parameter: STARVE_MAX, default 4, maximum consecutive data grants while inst_req is held before inst is forced a grant.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 resetn  input  1  reset, synchronous, active-low.
REQ-004 inst_req / inst_wr / inst_size / inst_addr / inst_wdata  input  1/1/2/32/32  instruction-side sram-like request.
REQ-005 inst_addr_ok / inst_data_ok  output  1/1  instruction-side handshake responses.
REQ-006 inst_rdata  output  32  instruction read data, valid when inst_data_ok=1.
REQ-007 data_req / data_wr / data_size / data_addr / data_wdata  input  1/1/2/32/32  data-side sram-like request.
REQ-008 data_addr_ok / data_data_ok  output  1/1  data-side handshake responses.
REQ-009 data_rdata  output  32  data read data, valid when data_data_ok=1.
REQ-010 mem_req / mem_wr / mem_size / mem_addr / mem_wdata  output  1/1/2/32/32  shared downstream request.
REQ-011 mem_addr_ok / mem_data_ok  input  1/1  downstream handshake.
REQ-012 mem_rdata  input  32  downstream read data.
REQ-013 stray_ok  output  1  one-cycle pulse: mem_data_ok seen with nothing outstanding.

Function
REQ-014 The block SHALL use two states: IDLE (nothing outstanding) and WAIT (one transaction outstanding); at most one transaction is outstanding at any time.
REQ-015 In IDLE, mem_req SHALL equal inst_req|data_req; in WAIT, mem_req SHALL be 0.
REQ-016 Grant in IDLE SHALL be combinational: data wins over inst, except when starve_cnt==STARVE_MAX and inst_req=1, in which case inst wins.
REQ-017 mem_wr/size/addr/wdata SHALL be driven from the granted requester; with no request they SHALL be driven from the data side.
REQ-018 Exactly one of inst_addr_ok/data_addr_ok SHALL equal mem_addr_ok, the one for the granted side, and only in IDLE; the other SHALL be 0.
REQ-019 On an address handshake (IDLE & mem_req & mem_addr_ok), the block SHALL register owner (0=inst, 1=data) and move to WAIT next cycle.
REQ-020 In WAIT, mem_data_ok SHALL be routed to the owner's data_ok in the same cycle, combinationally; the non-owner's data_ok SHALL be 0; state SHALL return to IDLE next cycle.
REQ-021 inst_rdata and data_rdata SHALL both equal mem_rdata; consumers qualify them with their own data_ok.
REQ-022 A new address SHALL NOT be issued in the cycle mem_data_ok returns; the minimum spacing between address handshakes is 2 cycles, given mem_data_ok 1 cycle after addr_ok.
REQ-023 starve_cnt, 3 bits and saturating at STARVE_MAX, SHALL:
- increment on each data handshake taken while inst_req=1;
- clear on any inst handshake;
- clear on a data handshake taken while inst_req=0.
REQ-024 mem_data_ok in IDLE SHALL produce no inst/data data_ok and SHALL pulse stray_ok for one cycle.
REQ-025 A requester dropping req before addr_ok SHALL cancel that request with no state change; arbitration re-evaluates every IDLE cycle.
REQ-026 Write transactions SHALL follow the same sequence; data_ok marks write completion.

Reset
REQ-027 While resetn=0 at a clock edge, state SHALL become IDLE, owner 0, starve_cnt 0.
REQ-028 During reset and the cycle after, all data_ok outputs and stray_ok SHALL be 0, and mem_req SHALL follow REQ-015 from IDLE.
REQ-029 A transaction in flight at reset SHALL be abandoned; its later mem_data_ok SHALL be treated as stray (REQ-024).

Verification
REQ-030 Simultaneous requests in IDLE: inst_req=1, data_req=1, data_addr=0x80001000, mem_addr_ok=1 -> mem_addr=0x80001000, data_addr_ok=1, inst_addr_ok=0, WAIT next cycle.
REQ-031 Routing: data read outstanding, mem_data_ok=1, mem_rdata=0xDEADBEEF -> data_data_ok=1, data_rdata=0xDEADBEEF, inst_data_ok=0, IDLE next cycle.
REQ-032 Starvation: inst_req held with data_req continuous -> data wins 4 handshakes, inst wins the 5th, starve_cnt then 0.
REQ-033 Back-pressure: mem_addr_ok=0 for 3 cycles with inst_req=1, inst_addr=0xBFC00000 -> mem_req=1 and mem_addr stable every cycle; inst_addr_ok=0 until mem_addr_ok=1.
REQ-034 Reset mid-transaction: resetn=0 in WAIT, then mem_data_ok=1 after release -> stray_ok=1 for 1 cycle, no data_ok asserted.
REQ-035 Spacing: mem_data_ok and pending data_req in the same WAIT cycle -> mem_req=0 that cycle, mem_req=1 the next.
